instr_fetch_buffer: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Takes the current PC value, issues instruction-ROM reads, and steps the PC with an inc pulse on each accepted request.
- Buffers returned instructions, tagged with their addresses, in a DEPTH-entry FIFO and presents them to CPU decode through a valid/ready handshake.
- A jump (PC load) flushes the buffer and discards any reads still in flight.

---
 rtl/instr_fetch_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// ============================================================================
// instr_fetch_buffer
// ----------------------------------------------------------------------------
// Fetch stage that sits directly behind the program counter. It issues
// instruction-ROM reads for the current PC and pulses pc_inc on every accepted
// request. Returned words are tagged with their fetch address and held in a
// DEPTH-entry FIFO. The FIFO is presented to decode through a valid/ready
// handshake. A flush (jump) empties the buffer. Reads that are still in flight
// during a flush are counted and discarded when they return.
//
// Parameters
//   DEPTH   FIFO entries, which is also the in-flight credit (power of two, >= 2)
//   ADDR_W  ROM address width; the low ADDR_W bits of pc are used (<= 16)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset, released synchronously
//   pc           current PC register value
//   pc_inc       PC increment pulse (imem_req & imem_gnt)
//   flush        jump taken; the PC loads its new target on this edge
//   imem_req     ROM read request (combinational credit check)
//   imem_addr    ROM read address, pc[ADDR_W-1:0]
//   imem_gnt     ROM accepted the request this cycle
//   imem_rvalid  ROM read data valid (in order, latency >= 1)
//   imem_rdata   ROM read data
//   instr_valid  FIFO head valid
//   instr_ready  decode accepts the head
//   instr        head instruction word
//   instr_addr   head instruction address
//
// Build option
//   FETCH_BYPASS_EN  when defined, a response that arrives while the FIFO is
//                    empty (and nothing is being dropped or flushed) is
//                    presented to decode in the same cycle. It is written into
//                    the FIFO only if decode does not take it.
// ============================================================================
module instr_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       pc,
    output logic              pc_inc,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Room for the sum of three counters, each of which can reach DEPTH.
    localparam int SUM_W = CNT_W + 2;

    // Instruction FIFO storage (data word and fetch address per entry).
    logic [15:0]       data_mem_r [DEPTH];
    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    // Address tags of reads in flight, in issue order.
    logic [ADDR_W-1:0] tag_mem_r  [DEPTH];

    logic [PTR_W-1:0]  fifo_rd_ptr_r, fifo_rd_ptr_n;
    logic [PTR_W-1:0]  fifo_wr_ptr_r, fifo_wr_ptr_n;
    logic [PTR_W-1:0]  tag_rd_ptr_r,  tag_rd_ptr_n;
    logic [PTR_W-1:0]  tag_wr_ptr_r,  tag_wr_ptr_n;
    logic [CNT_W-1:0]  fifo_cnt_r,    fifo_cnt_n;
    logic [CNT_W-1:0]  outstanding_r, outstanding_n;
    logic [CNT_W-1:0]  drop_cnt_r,    drop_cnt_n;

    logic [SUM_W-1:0]  credit_sum_s;
    logic [SUM_W-1:0]  drop_total_s;
    logic              req_s;
    logic              grant_s;
    logic              dropping_s;
    logic              resp_keep_s;
    logic              resp_drop_s;
    logic              fifo_empty_s;
    logic              bypass_s;
    logic              head_valid_s;
    logic              pop_s;
    logic              push_s;

    // The PC bits above the ROM address are unused by design because the
    // address wraps by truncation.
    generate
        if (ADDR_W < 16) begin : g_pc_hi
            logic unused_pc_hi_s;
            assign unused_pc_hi_s = ^pc[15:ADDR_W];
        end
    endgenerate

    // Credit check, request/grant and response/handshake qualifiers.
    always_comb begin
        credit_sum_s = SUM_W'(fifo_cnt_r) + SUM_W'(outstanding_r) + SUM_W'(drop_cnt_r);
        drop_total_s = SUM_W'(drop_cnt_r) + SUM_W'(outstanding_r);
        // Requests are masked during reset. With the counters cleared, the
        // credit check alone would otherwise request.
        req_s        = reset_n & ~flush & (credit_sum_s < SUM_W'(DEPTH));
        grant_s      = req_s & imem_gnt;
        dropping_s   = (drop_cnt_r != {CNT_W{1'b0}});
        // A response in the flush cycle is never kept; it is folded into the
        // new drop count instead.
        resp_keep_s  = reset_n & imem_rvalid & ~dropping_s & ~flush;
        resp_drop_s  = imem_rvalid & dropping_s & ~flush;
        fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
`ifdef FETCH_BYPASS_EN
        bypass_s     = fifo_empty_s & resp_keep_s;
`else
        bypass_s     = 1'b0;
`endif
        head_valid_s = ~fifo_empty_s | bypass_s;
        pop_s        = ~fifo_empty_s & instr_ready;
        // A bypassed word that decode takes right away never enters the FIFO.
        push_s       = resp_keep_s & ~(bypass_s & instr_ready);
    end

    // Next-state for pointers and counters; a flush overrides everything else.
    always_comb begin
        fifo_rd_ptr_n = fifo_rd_ptr_r;
        fifo_wr_ptr_n = fifo_wr_ptr_r;
        tag_rd_ptr_n  = tag_rd_ptr_r;
        tag_wr_ptr_n  = tag_wr_ptr_r;
        fifo_cnt_n    = fifo_cnt_r;
        outstanding_n = outstanding_r;
        drop_cnt_n    = drop_cnt_r;
        if (flush) begin
            fifo_rd_ptr_n = {PTR_W{1'b0}};
            fifo_wr_ptr_n = {PTR_W{1'b0}};
            tag_rd_ptr_n  = {PTR_W{1'b0}};
            tag_wr_ptr_n  = {PTR_W{1'b0}};
            fifo_cnt_n    = {CNT_W{1'b0}};
            outstanding_n = {CNT_W{1'b0}};
            // Every read still owed becomes a read to discard. The response
            // arriving in this cycle is already accounted for.
            if (imem_rvalid && (drop_total_s != {SUM_W{1'b0}})) begin
                drop_cnt_n = CNT_W'(drop_total_s - SUM_W'(1));
            end else begin
                drop_cnt_n = CNT_W'(drop_total_s);
            end
        end else begin
            fifo_cnt_n    = fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
            fifo_wr_ptr_n = push_s      ? fifo_wr_ptr_r + PTR_W'(1) : fifo_wr_ptr_r;
            fifo_rd_ptr_n = pop_s       ? fifo_rd_ptr_r + PTR_W'(1) : fifo_rd_ptr_r;
            tag_wr_ptr_n  = grant_s     ? tag_wr_ptr_r + PTR_W'(1)  : tag_wr_ptr_r;
            tag_rd_ptr_n  = resp_keep_s ? tag_rd_ptr_r + PTR_W'(1)  : tag_rd_ptr_r;
            // A grant and a kept response in the same cycle cancel out.
            outstanding_n = outstanding_r + CNT_W'(grant_s) - CNT_W'(resp_keep_s);
            drop_cnt_n    = resp_drop_s ? drop_cnt_r - CNT_W'(1) : drop_cnt_r;
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_rd_ptr_r <= {PTR_W{1'b0}};
            fifo_wr_ptr_r <= {PTR_W{1'b0}};
            tag_rd_ptr_r  <= {PTR_W{1'b0}};
            tag_wr_ptr_r  <= {PTR_W{1'b0}};
            fifo_cnt_r    <= {CNT_W{1'b0}};
            outstanding_r <= {CNT_W{1'b0}};
            drop_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            fifo_rd_ptr_r <= fifo_rd_ptr_n;
            fifo_wr_ptr_r <= fifo_wr_ptr_n;
            tag_rd_ptr_r  <= tag_rd_ptr_n;
            tag_wr_ptr_r  <= tag_wr_ptr_n;
            fifo_cnt_r    <= fifo_cnt_n;
            outstanding_r <= outstanding_n;
            drop_cnt_r    <= drop_cnt_n;
        end
    end

    // FIFO and tag storage. Everything is cleared at reset so that the head
    // outputs read zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= 16'h0000;
                addr_mem_r[i] <= {ADDR_W{1'b0}};
                tag_mem_r[i]  <= {ADDR_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                data_mem_r[fifo_wr_ptr_r] <= imem_rdata;
                addr_mem_r[fifo_wr_ptr_r] <= tag_mem_r[tag_rd_ptr_r];
            end
            if (grant_s) begin
                tag_mem_r[tag_wr_ptr_r] <= imem_addr;
            end
        end
    end

    // Output drive: the head comes from the FIFO, or from the ROM bus when
    // bypassing.
    always_comb begin
        pc_inc      = grant_s;
        imem_req    = req_s;
        imem_addr   = pc[ADDR_W-1:0];
        instr_valid = head_valid_s;
        if (bypass_s) begin
            instr      = imem_rdata;
            instr_addr = tag_mem_r[tag_rd_ptr_r];
        end else begin
            instr      = data_mem_r[fifo_rd_ptr_r];
            instr_addr = addr_mem_r[fifo_rd_ptr_r];
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Testbench for instr_fetch_buffer. The bench plays the PC register and an
// in-order instruction ROM with configurable latency. A queue-based reference
// model predicts the request, pc_inc and head outputs in every cycle.
module tb_instr_fetch_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 15;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } entry_t;

    typedef struct packed {
        logic [14:0] addr;
        int          due;
    } rom_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic        pc_inc;
    logic        flush;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [14:0] instr_addr;

    instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .pc_inc(pc_inc), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_addr(instr_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat_min = 1;
    int lat_max = 1;
    int m_drop  = 0;
    logic [15:0] flush_tgt = 16'h0000;

    entry_t      fifo_q[$];
    logic [14:0] infl_q[$];
    rom_t        rom_q[$];
    logic [14:0] hs_addr_q[$];
    logic [15:0] hs_data_q[$];

    logic        last_req, last_inc, last_valid;
    logic [14:0] last_addr;

    function automatic logic [15:0] rom_word(input logic [14:0] a);
        return {1'b0, a} ^ 16'hA5A5;
    endfunction

    // One clock cycle. Inputs flush/gnt/ready are set by the caller at
    // posedge+1. The ROM response is driven here, the outputs are checked
    // against the model, and then the model, ROM and PC advance over the edge.
    task automatic step();
        logic        rv, exp_req, exp_inc, byp, exp_valid;
        logic [14:0] exp_iaddr, a;
        logic [15:0] exp_instr;
        entry_t      e;
        rom_t        r;
        rv = (rom_q.size() > 0) && (rom_q[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? rom_word(rom_q[0].addr) : 16'($urandom);
        #1;
        exp_req   = !flush && ((fifo_q.size() + infl_q.size() + m_drop) < DEPTH);
        exp_inc   = exp_req && imem_gnt;
        byp       = BYP && (fifo_q.size() == 0) && (m_drop == 0) && rv && !flush && (infl_q.size() > 0);
        exp_valid = (fifo_q.size() > 0) || byp;
        exp_iaddr = 15'h0000;
        exp_instr = 16'h0000;
        if (byp) begin
            exp_iaddr = infl_q[0];
            exp_instr = imem_rdata;
        end else if (fifo_q.size() > 0) begin
            exp_iaddr = fifo_q[0].addr;
            exp_instr = fifo_q[0].data;
        end
        total++;
        if (imem_req !== exp_req) begin
            bad++; $display("FAIL imem_req cyc=%0d got=%0b want=%0b", cyc, imem_req, exp_req);
        end
        total++;
        if (pc_inc !== exp_inc) begin
            bad++; $display("FAIL pc_inc cyc=%0d got=%0b want=%0b", cyc, pc_inc, exp_inc);
        end
        total++;
        if (imem_addr !== pc[14:0]) begin
            bad++; $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, pc[14:0]);
        end
        total++;
        if (instr_valid !== exp_valid) begin
            bad++; $display("FAIL instr_valid cyc=%0d got=%0b want=%0b", cyc, instr_valid, exp_valid);
        end
        if (exp_valid) begin
            total++;
            if ({instr_addr, instr} !== {exp_iaddr, exp_instr}) begin
                bad++;
                $display("FAIL head cyc=%0d got=%h/%h want=%h/%h", cyc, instr_addr, instr, exp_iaddr, exp_instr);
            end
        end
        last_req   = imem_req;
        last_inc   = pc_inc;
        last_valid = instr_valid;
        last_addr  = imem_addr;
        if (instr_valid && instr_ready) begin
            hs_addr_q.push_back(instr_addr);
            hs_data_q.push_back(instr);
        end
        // Reference model update.
        if (flush) begin
            m_drop = m_drop + infl_q.size() - (rv ? 1 : 0);
            infl_q.delete();
            fifo_q.delete();
        end else begin
            if (exp_valid && instr_ready && !byp) void'(fifo_q.pop_front());
            if (rv) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    a = infl_q.pop_front();
                    if (!(byp && instr_ready)) begin
                        e.addr = a;
                        e.data = imem_rdata;
                        fifo_q.push_back(e);
                    end
                end
            end
            if (exp_inc) infl_q.push_back(pc[14:0]);
        end
        // ROM side.
        if (rv) void'(rom_q.pop_front());
        if (exp_inc) begin
            r.addr = pc[14:0];
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            rom_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (flush) pc = flush_tgt;
        else if (exp_inc) pc = pc + 16'd1;
    endtask

    task automatic do_reset(input logic [15:0] p);
        reset_n     = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        instr_ready = 1'b0;
        fifo_q.delete(); infl_q.delete(); rom_q.delete();
        hs_addr_q.delete(); hs_data_q.delete();
        m_drop = 0;
        pc = p;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
        imem_rdata = 16'h0000; instr_ready = 1'b1; pc = 16'h1234;
        #2;
        total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL rst_req got=%0b want=0", imem_req); end
        total++; if (pc_inc !== 1'b0)      begin bad++; $display("FAIL rst_inc got=%0b want=0", pc_inc); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", instr_valid); end
        total++; if (instr !== 16'h0000)   begin bad++; $display("FAIL rst_instr got=%h want=0000", instr); end
        total++; if (instr_addr !== 15'h0) begin bad++; $display("FAIL rst_iaddr got=%h want=0000", instr_addr); end
    endtask

    task automatic test_streaming();
        int fg, fv, n_hs;
        do_reset(16'h0000);
        lat_min = 1; lat_max = 1; imem_gnt = 1'b1; instr_ready = 1'b1;
        fg = -1; fv = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_inc && fg < 0) fg = i;
            if (last_valid && fv < 0) fv = i;
        end
        total++;
        if ((fv - fg) != (BYP ? 1 : 2)) begin
            bad++; $display("FAIL stream_latency got=%0d want=%0d", fv - fg, BYP ? 1 : 2);
        end
        n_hs = hs_addr_q.size();
        total++;
        if (n_hs != (BYP ? 19 : 18)) begin
            bad++; $display("FAIL stream_count got=%0d want=%0d", n_hs, BYP ? 19 : 18);
        end
        for (int i = 0; i < 10 && i < n_hs; i++) begin
            total++;
            if (hs_addr_q[i] !== 15'(i) || hs_data_q[i] !== (16'(i) ^ 16'hA5A5)) begin
                bad++; $display("FAIL stream_order i=%0d got=%h/%h", i, hs_addr_q[i], hs_data_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int grants;
        do_reset(16'h0000);
        lat_min = 1; lat_max = 1; imem_gnt = 1'b1; instr_ready = 1'b0;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_inc) grants++;
        end
        total++; if (grants != 4) begin bad++; $display("FAIL bp_grants got=%0d want=4", grants); end
        total++; if (last_req !== 1'b0 || last_inc !== 1'b0) begin
            bad++; $display("FAIL bp_stall req=%0b inc=%0b want=0/0", last_req, last_inc);
        end
        total++; if (last_addr !== 15'd4) begin bad++; $display("FAIL bp_pc got=%h want=0004", last_addr); end
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        total++;
        if (hs_addr_q.size() < 5) begin
            bad++; $display("FAIL bp_drain got=%0d want>=5", hs_addr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (hs_addr_q[i] !== 15'(i)) begin
                    bad++; $display("FAIL bp_order i=%0d got=%h want=%h", i, hs_addr_q[i], 15'(i));
                end
            end
        end
    endtask

    task automatic test_grant_stall();
        do_reset(16'h0007);
        lat_min = 1; lat_max = 2; imem_gnt = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (last_req !== 1'b1 || last_addr !== 15'd7 || last_inc !== 1'b0 || pc !== 16'd7) begin
                bad++; $display("FAIL stall i=%0d req=%0b addr=%h inc=%0b", i, last_req, last_addr, last_inc);
            end
        end
        imem_gnt = 1'b1;
        step();
        total++; if (last_inc !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b want=1", last_inc); end
    endtask

    task automatic test_flush();
        do_reset(16'h0000);
        lat_min = 3; lat_max = 3; imem_gnt = 1'b1; instr_ready = 1'b1;
        step(); step();
        flush = 1'b1; flush_tgt = 16'd100;
        step();
        flush = 1'b0;
        total++; if (last_req !== 1'b0) begin bad++; $display("FAIL flush_req got=%0b want=0", last_req); end
        hs_addr_q.delete(); hs_data_q.delete();
        for (int i = 0; i < 12; i++) step();
        total++;
        if (hs_addr_q.size() == 0) begin
            bad++; $display("FAIL flush_next got=none want=0064");
        end else if (hs_addr_q[0] !== 15'd100) begin
            bad++; $display("FAIL flush_next got=%h want=0064", hs_addr_q[0]);
        end
        foreach (hs_addr_q[i]) begin
            if (hs_addr_q[i] < 15'd100) begin
                total++; bad++; $display("FAIL flush_stale got=%h", hs_addr_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] pc_rel;
        int n;
        do_reset(16'h0000);
        lat_min = 1; lat_max = 1; imem_gnt = 1'b1; instr_ready = 1'b0;
        n = 0;
        while (fifo_q.size() != 3 && n < 12) begin step(); n++; end
        total++;
        if (fifo_q.size() != 3) begin bad++; $display("FAIL mid_fill got=%0d want=3", fifo_q.size()); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%0b want=1", instr_valid); end
        imem_rvalid = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_inc !== 1'b0) begin
            bad++; $display("FAIL mid_async valid=%0b req=%0b inc=%0b want=0/0/0", instr_valid, imem_req, pc_inc);
        end
        fifo_q.delete(); infl_q.delete(); rom_q.delete(); m_drop = 0;
        hs_addr_q.delete(); hs_data_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        pc_rel = pc;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        total++;
        if (hs_addr_q.size() == 0 || hs_addr_q[0] !== pc_rel[14:0]) begin
            bad++; $display("FAIL mid_restart got=%0d entries want first=%h", hs_addr_q.size(), pc_rel[14:0]);
        end
    endtask

    task automatic test_truncation();
        do_reset(16'hFFFF);
        lat_min = 1; lat_max = 1; imem_gnt = 1'b1; instr_ready = 1'b1;
        step();
        total++; if (last_addr !== 15'h7FFF || last_inc !== 1'b1) begin
            bad++; $display("FAIL trunc_addr got=%h inc=%0b want=7fff/1", last_addr, last_inc);
        end
        for (int i = 0; i < 5; i++) step();
        total++;
        if (hs_addr_q.size() < 2) begin
            bad++; $display("FAIL trunc_entry got=%0d entries want>=2", hs_addr_q.size());
        end else if (hs_addr_q[0] !== 15'h7FFF || hs_data_q[0] !== 16'hDA5A || hs_addr_q[1] !== 15'h0000) begin
            bad++; $display("FAIL trunc_entry got=%h/%h next=%h", hs_addr_q[0], hs_data_q[0], hs_addr_q[1]);
        end
    endtask

    task automatic test_random();
        do_reset(16'($urandom));
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            imem_gnt    = ($urandom_range(3, 0) != 0);
            instr_ready = ($urandom_range(2, 0) != 0);
            flush       = ($urandom_range(24, 0) == 0);
            flush_tgt   = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
            step();
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_grant_stall();
        test_flush();
        test_reset_mid();
        test_truncation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
